pipe_hazard_ctrl: RTL

- Hazard/sequencing controller for the 5-stage MIPS pipeline.
- Decides each cycle whether PC and IF/ID advance, hold, or flush, and whether ID/EX captures the decoded instruction or a bubble (10-bit control forced to zero).
- Covers three cases: load-use stall, taken-branch flush, and multi-cycle multiply/divide stall.
- Also keeps saturating stall/flush event counters for performance debug.

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/sat_counter.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared encodings and helpers for the pipeline hazard controller
package pipe_pkg;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MDU_WAIT = 1'b1
   } state_t;

   // ID/EX out_ctl bit positions
   localparam int CTL_W        = 10;
   localparam int CTL_REGDST   = 9;
   localparam int CTL_ALUSRC   = 8;
   localparam int CTL_ALUOP_HI = 7;
   localparam int CTL_ALUOP_LO = 6;
   localparam int CTL_BRANCH   = 5;
   localparam int CTL_MEMREAD  = 4;

   localparam logic [CTL_W-1:0] CTL_NOP = '0;

   function automatic logic load_use_hazard(
      input logic [4:0] id_rs,
      input logic [4:0] id_rt,
      input logic       id_use_rs,
      input logic       id_use_rt,
      input logic       ex_memread,
      input logic [4:0] ex_rt
   );
      return ex_memread && (ex_rt != 5'd0) &&
             ((id_use_rs && (id_rs == ex_rt)) || (id_use_rt && (id_rt == ex_rt)));
   endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - event counter that sticks at all-ones instead of wrapping
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - PC/IF/ID/ID-EX sequencing for load-use, taken-branch and mul/div hazards
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MDU_LAT = 4,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             ex_memread,
   input  logic [4:0]       ex_rt,
   input  logic             ex_mdu,
   input  logic             mem_br_taken,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             ex_hold,
   output logic             exmem_flush,
   output logic             busy,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [3:0] MDU_LOAD = 4'(MDU_LAT - 1);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_mdu_cnt;
   logic [3:0] w_mdu_cnt_nxt;
   logic       w_load_use;
   logic       w_stall_inc;
   logic       w_flush_inc;

   assign w_load_use = load_use_hazard(id_rs, id_rt, id_use_rs, id_use_rt, ex_memread, ex_rt);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_RUN;
         r_mdu_cnt <= 4'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_mdu_cnt <= w_mdu_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_mdu_cnt_nxt = r_mdu_cnt;
      w_stall_inc   = 1'b0;
      w_flush_inc   = 1'b0;
      pc_write      = 1'b1;
      ifid_write    = 1'b1;
      ifid_flush    = 1'b0;
      idex_bubble   = 1'b0;
      ex_hold       = 1'b0;
      exmem_flush   = 1'b0;
      busy          = 1'b0;

      if (!rst) begin
         busy = (r_state == ST_MDU_WAIT);
         if (mem_br_taken) begin
            // Wrong-path work, including any in-flight mul/div, is discarded
            ifid_flush    = 1'b1;
            idex_bubble   = 1'b1;
            exmem_flush   = 1'b1;
            w_state_nxt   = ST_RUN;
            w_mdu_cnt_nxt = 4'd0;
            w_flush_inc   = 1'b1;
         end else if (r_state == ST_MDU_WAIT) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ex_hold     = 1'b1;
            exmem_flush = 1'b1;
            w_stall_inc = 1'b1;
            if (r_mdu_cnt == 4'd1) begin
               w_state_nxt   = ST_RUN;
               w_mdu_cnt_nxt = 4'd0;
            end else begin
               w_mdu_cnt_nxt = r_mdu_cnt - 4'd1;
            end
         end else if (ex_mdu) begin
            pc_write      = 1'b0;
            ifid_write    = 1'b0;
            ex_hold       = 1'b1;
            exmem_flush   = 1'b1;
            w_stall_inc   = 1'b1;
            w_state_nxt   = ST_MDU_WAIT;
            w_mdu_cnt_nxt = MDU_LOAD;
         end else if (w_load_use) begin
            // One bubble suffices: next cycle the load has moved to MEM
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            w_stall_inc = 1'b1;
         end
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .i_clk   (clk),
      .i_clr   (rst),
      .i_inc   (w_stall_inc),
      .o_count (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .i_clk   (clk),
      .i_clr   (rst),
      .i_inc   (w_flush_inc),
      .o_count (flush_cnt)
   );

endmodule
